sio_tx_scheduler: RTL
=====================

SIO_TX_SCHEDULER -- requirements
Module: sio_tx_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX byte queue depth (power of two).
REQ-002 SHALL have parameter POLL_GAP, default 8, idle cycles between TX-status polls while the UART is busy.
REQ-003 SHALL have parameter TX_READY_BIT, default 0, bit of the TX-status word meaning the transmitter can accept a byte.
REQ-004 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 host_addr  in  5  register address from the HPS bridge.
REQ-007 host_enable  in  1  one-cycle host read strobe.
REQ-008 host_wr  in  1  one-cycle host write strobe.
REQ-009 host_wdata  in  8  host write data.
REQ-010 host_rdata  out  16  host read data, wired directly to uart_data_read.
REQ-011 txq_data  in  8  byte to queue.
REQ-012 txq_valid  in  1  push request.
REQ-013 txq_ready  out  1  queue not full.
REQ-014 txq_flush  in  1  one-cycle queue clear.
REQ-015 txq_count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-016 busy  out  1  engine is not in IDLE.
REQ-017 uart_addr/uart_enable/uart_wr/uart_data_write  out  5/1/1/8  shared Pokey SIO UART register port.
REQ-018 uart_data_read  in  16  UART read data, valid the cycle after uart_enable.

Function
REQ-019 Host SHALL have absolute priority: when host_enable or host_wr is 1, the UART port SHALL carry the host fields combinationally in the same cycle, with zero latency.
REQ-020 When the host is idle, the port SHALL carry the engine request; it SHALL be all-zero when the engine has no request.
REQ-021 Push SHALL occur when txq_valid and txq_ready are both 1; txq_ready = (txq_count != FIFO_DEPTH).
REQ-022 A push when full SHALL be dropped; txq_count SHALL be unchanged.
REQ-023 A simultaneous push and pop SHALL leave txq_count unchanged and keep FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 States SHALL be IDLE, POLL, POLL_WAIT, WRITE and GAP.
REQ-026 IDLE -> POLL when txq_count > 0.
REQ-027 In POLL the engine SHALL request a read of addr 5'h1 (uart_enable=1); the state SHALL advance to POLL_WAIT only in a cycle where the request is granted (host idle), else it stays in POLL.
REQ-028 In POLL_WAIT the engine SHALL sample uart_data_read[TX_READY_BIT]: 1 -> WRITE, 0 -> GAP.
REQ-029 In WRITE the engine SHALL request a write of addr 5'h0 with data = FIFO head (uart_wr=1).
REQ-030 On grant in WRITE, the engine SHALL pop the head and go to IDLE; without grant it SHALL hold the request.
REQ-031 GAP SHALL count POLL_GAP cycles, then go to POLL; the counter SHALL reload on each entry.
REQ-032 txq_flush SHALL empty the queue and force IDLE next cycle from any state; a WRITE granted in the flush cycle still completes, and flush wins over the pop.
REQ-033 A push coinciding with txq_flush SHALL be discarded.
REQ-034 busy = (state != IDLE).

Reset
REQ-035 With reset_n low: state=IDLE, pointers=0, txq_count=0, txq_ready=1, busy=0, gap counter=0, engine request cleared, so the UART port is all-zero absent host strobes.
REQ-036 Reset SHALL act immediately and asynchronously, including mid-WRITE, with no port activity during reset beyond host passthrough.

Verification
REQ-037 Push 0x11,0x22,0x33 with status 0x0001 -> three poll(addr1)/write(addr0) pairs writing 0x11,0x22,0x33 in order; txq_count ends at 0 and busy=0.
REQ-038 Status 0x0000 for two polls, then 0x0001 -> polls spaced by exactly 8 GAP cycles, then one write.
REQ-039 host_wr with addr 5'h4, data 0x28 in the engine's POLL cycle -> port shows host addr 4/data 0x28; the engine poll appears the next cycle.
REQ-040 Push 17 bytes with the UART held busy -> txq_ready=0 after 16; the 17th is dropped; txq_count=16.
REQ-041 txq_flush during POLL_WAIT with 5 queued -> txq_count=0, IDLE next cycle, no write issued.
REQ-042 reset_n low in a WRITE cycle -> uart_wr=0 and txq_count=0 immediately; no write after release until a new push.

Source files
------------

// File: rtl/sio_tx_scheduler.sv
// TX byte queue feeding the shared Pokey SIO UART register port. The engine polls
// TX status and writes queued bytes; host bridge accesses always pre-empt it.
module sio_tx_scheduler #(
   parameter int FIFO_DEPTH   = 16,
   parameter int POLL_GAP     = 8,
   parameter int TX_READY_BIT = 0
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic [4:0]                    host_addr,
   input  logic                          host_enable,
   input  logic                          host_wr,
   input  logic [7:0]                    host_wdata,
   output logic [15:0]                   host_rdata,
   input  logic [7:0]                    txq_data,
   input  logic                          txq_valid,
   output logic                          txq_ready,
   input  logic                          txq_flush,
   output logic [$clog2(FIFO_DEPTH):0]   txq_count,
   output logic                          busy,
   output logic [4:0]                    uart_addr,
   output logic                          uart_enable,
   output logic                          uart_wr,
   output logic [7:0]                    uart_data_write,
   input  logic [15:0]                   uart_data_read
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] POLL      = 3'd1;
   localparam logic [2:0] POLL_WAIT = 3'd2;
   localparam logic [2:0] WRITE     = 3'd3;
   localparam logic [2:0] GAP       = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic       grant, push, pop;
   logic [4:0] eng_addr;
   logic       eng_en, eng_wr;
   logic [7:0] eng_data;

   assign grant      = !(host_enable || host_wr);
   assign txq_ready  = (count_q != CW'(FIFO_DEPTH));
   assign txq_count  = count_q;
   assign busy       = (state_q != IDLE);
   assign host_rdata = uart_data_read;
   assign push       = txq_valid && txq_ready && !txq_flush;
   assign pop        = (state_q == WRITE) && grant && !txq_flush;

   // Request decodes straight from state so an async reset drops it at once.
   always_comb begin
      eng_addr = 5'h0;
      eng_en   = 1'b0;
      eng_wr   = 1'b0;
      eng_data = 8'h0;
      case (state_q)
         POLL: begin
            eng_addr = 5'h1;
            eng_en   = 1'b1;
         end
         WRITE: begin
            eng_wr   = 1'b1;
            eng_data = mem_q[rd_ptr_q];
         end
         default: ;
      endcase
   end

   always_comb begin
      if (!grant) begin
         uart_addr       = host_addr;
         uart_enable     = host_enable;
         uart_wr         = host_wr;
         uart_data_write = host_wdata;
      end else begin
         uart_addr       = eng_addr;
         uart_enable     = eng_en;
         uart_wr         = eng_wr;
         uart_data_write = eng_data;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE:      if (count_q != '0) state_d = POLL;
         POLL:      if (grant) state_d = POLL_WAIT;
         POLL_WAIT: begin
            if (uart_data_read[TX_READY_BIT]) begin
               state_d = WRITE;
            end else begin
               state_d = GAP;
               gap_d   = GW'(POLL_GAP - 1);
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = POLL;
            else             gap_d   = gap_q - 1'b1;
         end
         WRITE:     if (grant) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      if (txq_flush) state_d = IDLE;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
      if (txq_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wr_ptr_q] <= txq_data;
   end

endmodule
